// File: rtl/serial_sub16_pkg.sv
// rtl/serial_sub16_pkg.sv - shared types and constants for the serial subtractor
// FSM state encoding, default width and the set of supported slice widths.
package sub16_pkg;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_e;

  localparam int DEF_WIDTH = 16;
  localparam int BPC_LEGAL [5] = '{1, 2, 4, 8, 16};

  function automatic bit bpc_legal(input int width, input int bpc);
    bit found;
    found = 1'b0;
    for (int i = 0; i < 5; i++) begin
      if (BPC_LEGAL[i] == bpc) found = 1'b1;
    end
    return found && (bpc <= width) && ((width % bpc) == 0);
  endfunction

endpackage

// File: rtl/serial_sub16_if.sv
// rtl/serial_sub16_if.sv - start/busy/done operand and result bundle
// The requester drives operands and start; the subtractor returns status and result.
interface serial_sub16_if
  import sub16_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
) ();

  logic             start;
  logic [WIDTH-1:0] x;
  logic [WIDTH-1:0] y;
  logic             bin;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] diff;
  logic             bout;
  logic             ovf;

  modport master (
    output start, x, y, bin,
    input  busy, done, diff, bout, ovf
  );

  modport slave (
    input  start, x, y, bin,
    output busy, done, diff, bout, ovf
  );

endinterface

// File: rtl/serial_sub16_slice.sv
// rtl/serial_sub16_slice.sv - N-bit ripple full-subtractor chain
// Purely combinational; the borrow ripples from bit 0 upward.
module sub_slice #(
  parameter int N = 1
) (
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  input  logic         bi,
  output logic [N-1:0] d,
  output logic         bo
);

  logic c;

  always_comb begin
    c = bi;
    d = '0;
    for (int i = 0; i < N; i++) begin
      d[i] = a[i] ^ b[i] ^ c;
      c    = (~a[i] & b[i]) | (~(a[i] ^ b[i]) & c);
    end
    bo = c;
  end

endmodule

// File: rtl/serial_sub16.sv
// rtl/serial_sub16.sv - multi-cycle subtractor, BPC bits per cycle, LSB first
// Result registers update only on the DONE cycle and hold until the next one.
module serial_sub16
  import sub16_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int BPC   = 1
) (
  input  logic           clk,
  input  logic           rst_n,
  serial_sub16_if.slave  bus
);

  localparam int NCHUNK = WIDTH / BPC;
  localparam int CNT_W  = $clog2(NCHUNK + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(NCHUNK - 1);

  if (!bpc_legal(WIDTH, BPC)) begin : g_bpc_check
    $error("serial_sub16: BPC must be one of 1,2,4,8,16 and divide WIDTH");
  end

  state_e           state_q;
  logic [WIDTH-1:0] xs_q, ys_q, acc_q, diff_q;
  logic [CNT_W-1:0] cnt_q;
  logic             br_q, sx_q, sy_q;
  logic             busy_q, done_q, bout_q, ovf_q;

  logic [BPC-1:0]   chunk_d;
  logic             br_d;
  logic [WIDTH-1:0] acc_d;
  logic             accept;

  sub_slice #(.N(BPC)) u_slice (
    .a  (xs_q[BPC-1:0]),
    .b  (ys_q[BPC-1:0]),
    .bi (br_q),
    .d  (chunk_d),
    .bo (br_d)
  );

  // Chunks enter at the MSB end so after NCHUNK shifts the first one sits at bit 0.
  assign acc_d  = (acc_q >> BPC) | (WIDTH'(chunk_d) << (WIDTH - BPC));
  assign accept = bus.start && (state_q == S_IDLE || state_q == S_DONE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      xs_q    <= '0;
      ys_q    <= '0;
      acc_q   <= '0;
      diff_q  <= '0;
      cnt_q   <= '0;
      br_q    <= 1'b0;
      sx_q    <= 1'b0;
      sy_q    <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      bout_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      done_q <= 1'b0;
      if (accept) begin
        xs_q  <= bus.x;
        ys_q  <= bus.y;
        br_q  <= bus.bin;
        sx_q  <= bus.x[WIDTH-1];
        sy_q  <= bus.y[WIDTH-1];
        acc_q <= '0;
        cnt_q <= '0;
      end
      case (state_q)
        S_IDLE: begin
          if (bus.start) begin
            state_q <= S_RUN;
            busy_q  <= 1'b1;
          end
        end
        S_RUN: begin
          xs_q  <= xs_q >> BPC;
          ys_q  <= ys_q >> BPC;
          acc_q <= acc_d;
          br_q  <= br_d;
          cnt_q <= cnt_q + CNT_W'(1);
          if (cnt_q == CNT_LAST) begin
            state_q <= S_DONE;
            busy_q  <= 1'b0;
          end
        end
        S_DONE: begin
          done_q  <= 1'b1;
          diff_q  <= acc_q;
          bout_q  <= br_q;
          ovf_q   <= (sx_q != sy_q) && (acc_q[WIDTH-1] != sx_q);
          state_q <= bus.start ? S_RUN : S_IDLE;
          busy_q  <= bus.start;
        end
        default: begin
          state_q <= S_IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.busy = busy_q;
  assign bus.done = done_q;
  assign bus.diff = diff_q;
  assign bus.bout = bout_q;
  assign bus.ovf  = ovf_q;

endmodule

// File: tb/tb_serial_sub16.sv
// tb/tb_serial_sub16.sv - directed bench for serial_sub16 at BPC 1, 4 and 16
module tb_serial_sub16;

  logic clk;
  logic rst_n;
  int   tests;
  int   fails;

  serial_sub16_if #(.WIDTH(16)) if1 ();
  serial_sub16_if #(.WIDTH(16)) if4 ();
  serial_sub16_if #(.WIDTH(16)) if16 ();

  serial_sub16 #(.WIDTH(16), .BPC(1))  u_dut1  (.clk(clk), .rst_n(rst_n), .bus(if1));
  serial_sub16 #(.WIDTH(16), .BPC(4))  u_dut4  (.clk(clk), .rst_n(rst_n), .bus(if4));
  serial_sub16 #(.WIDTH(16), .BPC(16)) u_dut16 (.clk(clk), .rst_n(rst_n), .bus(if16));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_op(input logic [15:0] a, input logic [15:0] b, input logic c,
                       output int lat, output int busyc);
    if1.x = a; if1.y = b; if1.bin = c; if1.start = 1'b1;
    tick();
    if1.start = 1'b0;
    busyc = if1.busy ? 1 : 0;
    lat = 0;
    while (lat < 40 && !if1.done) begin
      tick();
      lat++;
      if (if1.busy) busyc++;
    end
    if (!if1.done) lat = -1;
  endtask

  task automatic test_reset();
    int seen_done;
    rst_n = 1'b0;
    tick();
    tests++; if (if1.busy !== 1'b0) begin fails++; $display("FAIL reset_busy got %b want 0", if1.busy); end
    tests++; if (if1.done !== 1'b0) begin fails++; $display("FAIL reset_done got %b want 0", if1.done); end
    tests++; if (if1.diff !== 16'h0) begin fails++; $display("FAIL reset_diff got %h want 0000", if1.diff); end
    tests++; if (if1.bout !== 1'b0) begin fails++; $display("FAIL reset_bout got %b want 0", if1.bout); end
    tests++; if (if1.ovf !== 1'b0) begin fails++; $display("FAIL reset_ovf got %b want 0", if1.ovf); end
    rst_n = 1'b1;
    tick();
    if1.x = 16'd5000; if1.y = 16'd3000; if1.bin = 1'b0; if1.start = 1'b1;
    tick();
    if1.start = 1'b0;
    repeat (8) tick();
    rst_n = 1'b0;
    #1;
    tests++; if (if1.busy !== 1'b0) begin fails++; $display("FAIL abort_busy got %b want 0", if1.busy); end
    repeat (2) tick();
    rst_n = 1'b1;
    seen_done = 0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (if1.done || if1.busy) seen_done++;
    end
    tests++; if (seen_done !== 0) begin fails++; $display("FAIL abort_no_done got %0d active cycles want 0", seen_done); end
    tests++; if (if1.diff !== 16'h0) begin fails++; $display("FAIL abort_diff got %h want 0000", if1.diff); end
  endtask

  task automatic test_basic();
    int lat, busyc;
    do_op(16'd5000, 16'd3000, 1'b0, lat, busyc);
    tests++; if (lat !== 17) begin fails++; $display("FAIL basic_latency got %0d want 17", lat); end
    tests++; if (busyc !== 16) begin fails++; $display("FAIL basic_busy_cycles got %0d want 16", busyc); end
    tests++; if (if1.diff !== 16'h07D0) begin fails++; $display("FAIL basic_diff got %h want 07d0", if1.diff); end
    tests++; if (if1.bout !== 1'b0) begin fails++; $display("FAIL basic_bout got %b want 0", if1.bout); end
    tests++; if (if1.ovf !== 1'b0) begin fails++; $display("FAIL basic_ovf got %b want 0", if1.ovf); end
  endtask

  task automatic test_borrow();
    int lat, busyc;
    do_op(16'd0, 16'd1, 1'b0, lat, busyc);
    tests++; if (if1.diff !== 16'hFFFF) begin fails++; $display("FAIL borrow1_diff got %h want ffff", if1.diff); end
    tests++; if (if1.bout !== 1'b1) begin fails++; $display("FAIL borrow1_bout got %b want 1", if1.bout); end
    tests++; if (if1.ovf !== 1'b0) begin fails++; $display("FAIL borrow1_ovf got %b want 0", if1.ovf); end
    do_op(16'd1000, 16'd1000, 1'b1, lat, busyc);
    tests++; if (if1.diff !== 16'hFFFF) begin fails++; $display("FAIL borrow2_diff got %h want ffff", if1.diff); end
    tests++; if (if1.bout !== 1'b1) begin fails++; $display("FAIL borrow2_bout got %b want 1", if1.bout); end
  endtask

  task automatic test_overflow();
    int lat, busyc;
    do_op(16'h8000, 16'h0001, 1'b0, lat, busyc);
    tests++; if (if1.diff !== 16'h7FFF) begin fails++; $display("FAIL ovf1_diff got %h want 7fff", if1.diff); end
    tests++; if (if1.bout !== 1'b0) begin fails++; $display("FAIL ovf1_bout got %b want 0", if1.bout); end
    tests++; if (if1.ovf !== 1'b1) begin fails++; $display("FAIL ovf1_ovf got %b want 1", if1.ovf); end
    do_op(16'h7FFF, 16'hFFFF, 1'b0, lat, busyc);
    tests++; if (if1.diff !== 16'h8000) begin fails++; $display("FAIL ovf2_diff got %h want 8000", if1.diff); end
    tests++; if (if1.bout !== 1'b1) begin fails++; $display("FAIL ovf2_bout got %b want 1", if1.bout); end
    tests++; if (if1.ovf !== 1'b1) begin fails++; $display("FAIL ovf2_ovf got %b want 1", if1.ovf); end
  endtask

  task automatic test_ignore_start();
    int lat;
    if1.x = 16'd100; if1.y = 16'd30; if1.bin = 1'b0; if1.start = 1'b1;
    tick();
    lat = 0;
    while (lat < 40 && !if1.done) begin
      if1.x = 16'($urandom); if1.y = 16'($urandom); if1.bin = 1'($urandom);
      if (!if1.busy) if1.start = 1'b0;
      tick();
      lat++;
    end
    if1.start = 1'b0;
    tests++; if (lat !== 17) begin fails++; $display("FAIL ignore_latency got %0d want 17", lat); end
    tests++; if (if1.diff !== 16'd70) begin fails++; $display("FAIL ignore_diff got %h want 0046", if1.diff); end
    tick();
    tests++; if (if1.busy !== 1'b0) begin fails++; $display("FAIL ignore_no_restart got busy %b want 0", if1.busy); end
  endtask

  task automatic test_back_to_back();
    int wait_c, lat, held_bad;
    if1.x = 16'd300; if1.y = 16'd100; if1.bin = 1'b0; if1.start = 1'b1;
    tick();
    if1.start = 1'b0;
    wait_c = 0;
    tick();
    while (wait_c < 40 && if1.busy) begin tick(); wait_c++; end
    if1.x = 16'd50; if1.y = 16'd80; if1.bin = 1'b1; if1.start = 1'b1;
    tick();
    if1.start = 1'b0;
    tests++; if (if1.done !== 1'b1) begin fails++; $display("FAIL b2b_first_done got %b want 1", if1.done); end
    tests++; if (if1.diff !== 16'h00C8) begin fails++; $display("FAIL b2b_first_diff got %h want 00c8", if1.diff); end
    tests++; if (if1.busy !== 1'b1) begin fails++; $display("FAIL b2b_second_busy got %b want 1", if1.busy); end
    lat = 0; held_bad = 0;
    while (lat < 40) begin
      tick();
      lat++;
      if (if1.done) break;
      if (if1.diff !== 16'h00C8) held_bad++;
    end
    tests++; if (lat !== 17) begin fails++; $display("FAIL b2b_second_latency got %0d want 17", lat); end
    tests++; if (held_bad !== 0) begin fails++; $display("FAIL b2b_hold got %0d changed cycles want 0", held_bad); end
    tests++; if (if1.diff !== 16'hFFE1) begin fails++; $display("FAIL b2b_second_diff got %h want ffe1", if1.diff); end
    tests++; if (if1.bout !== 1'b1) begin fails++; $display("FAIL b2b_second_bout got %b want 1", if1.bout); end
  endtask

  task automatic test_sweep();
    logic [15:0] xv, yv;
    logic        bv;
    logic [16:0] s1, s4, s16;
    int          l1, l4, l16;
    xv = 16'd0; yv = 16'd0;
    for (int op = 0; op < 200; op++) begin
      bv = op[0];
      if1.x = xv; if1.y = yv; if1.bin = bv; if1.start = 1'b1;
      if4.x = xv; if4.y = yv; if4.bin = bv; if4.start = 1'b1;
      if16.x = xv; if16.y = yv; if16.bin = bv; if16.start = 1'b1;
      tick();
      if1.start = 1'b0; if4.start = 1'b0; if16.start = 1'b0;
      l1 = -1; l4 = -1; l16 = -1;
      s1 = '0; s4 = '0; s16 = '0;
      for (int c = 1; c <= 20; c++) begin
        tick();
        // An adder sees diff + y + bin carry out exactly when the subtraction borrowed.
        if (if1.done)  begin l1 = c;  s1  = {1'b0, if1.diff}  + {1'b0, yv} + 17'(bv); end
        if (if4.done)  begin l4 = c;  s4  = {1'b0, if4.diff}  + {1'b0, yv} + 17'(bv); end
        if (if16.done) begin l16 = c; s16 = {1'b0, if16.diff} + {1'b0, yv} + 17'(bv); end
      end
      tests++; if (l1 !== 17) begin fails++; $display("FAIL sweep%0d_bpc1_latency got %0d want 17", op, l1); end
      tests++; if (l4 !== 5) begin fails++; $display("FAIL sweep%0d_bpc4_latency got %0d want 5", op, l4); end
      tests++; if (l16 !== 2) begin fails++; $display("FAIL sweep%0d_bpc16_latency got %0d want 2", op, l16); end
      tests++; if (s1[15:0] !== xv) begin fails++; $display("FAIL sweep%0d_bpc1_sum got %h want %h", op, s1[15:0], xv); end
      tests++; if (s4[15:0] !== xv) begin fails++; $display("FAIL sweep%0d_bpc4_sum got %h want %h", op, s4[15:0], xv); end
      tests++; if (s16[15:0] !== xv) begin fails++; $display("FAIL sweep%0d_bpc16_sum got %h want %h", op, s16[15:0], xv); end
      tests++; if (s1[16] !== if1.bout) begin fails++; $display("FAIL sweep%0d_bpc1_carry got %b want %b", op, if1.bout, s1[16]); end
      tests++; if (s4[16] !== if4.bout) begin fails++; $display("FAIL sweep%0d_bpc4_carry got %b want %b", op, if4.bout, s4[16]); end
      tests++; if (s16[16] !== if16.bout) begin fails++; $display("FAIL sweep%0d_bpc16_carry got %b want %b", op, if16.bout, s16[16]); end
      xv = xv + 16'd1000;
      yv = yv + 16'd3000;
    end
  endtask

  initial begin
    tests = 0; fails = 0;
    rst_n = 1'b0;
    if1.start = 1'b0;  if1.x = '0;  if1.y = '0;  if1.bin = 1'b0;
    if4.start = 1'b0;  if4.x = '0;  if4.y = '0;  if4.bin = 1'b0;
    if16.start = 1'b0; if16.x = '0; if16.y = '0; if16.bin = 1'b0;
    test_reset();
    test_basic();
    test_borrow();
    test_overflow();
    test_ignore_start();
    test_back_to_back();
    test_sweep();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
